// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b (mod 2^WIDTH), LSB first, one bit per clock.
// Operands are descrambled with fixed XOR masks at load; final borrow flags a < b.
module sub_serial #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] A_MASK = 8'hE8,
  parameter logic [WIDTH-1:0] B_MASK = 8'h96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SUB  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, out_reg;
  logic [CW-1:0]    count_reg;
  logic             brw_reg;
  logic             diff_bit, brw_next;

  assign diff_bit = a_reg[0] ^ b_reg[0] ^ brw_reg;
  assign brw_next = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & brw_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (en) state_next = LOAD;
      LOAD: state_next = SUB;
      SUB:  if (count_reg == LAST) state_next = DONE;
      DONE: if (en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == LOAD) || (state_reg == SUB);
    done = (state_reg == DONE);
  end

  // Result and borrow stay held through DONE and IDLE until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      out_reg   <= '0;
      count_reg <= '0;
      brw_reg   <= 1'b0;
    end else if (state_reg == IDLE && en) begin
      a_reg     <= a ^ A_MASK;
      b_reg     <= b ^ B_MASK;
      out_reg   <= '0;
      count_reg <= '0;
      brw_reg   <= 1'b0;
    end else if (state_reg == SUB) begin
      out_reg   <= {diff_bit, out_reg[WIDTH-1:1]};
      a_reg     <= a_reg >> 1;
      b_reg     <= b_reg >> 1;
      brw_reg   <= brw_next;
      count_reg <= count_reg + 1'b1;
    end
  end

  assign out    = out_reg;
  assign borrow = brw_reg;

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: one instance with zero masks, one with default masks, shared stimulus.
module tb_sub_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] out0, out1;
  logic       borrow0, borrow1, busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sub_serial #(.WIDTH(8), .A_MASK(8'h00), .B_MASK(8'h00)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .out(out0), .borrow(borrow0), .busy(busy0), .done(done0)
  );

  sub_serial #(.WIDTH(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
    .out(out1), .borrow(borrow1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start at the next edge; returns 1ns after that edge with en low.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    a  = av;
    b  = bv;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  // Wait for done (bounded); report edges since start and busy cycles seen.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = busy0 ? 1 : 0;
    while (!done0 && edges < 20) begin
      tick();
      edges++;
      if (busy0) busy_cnt++;
    end
  endtask

  task automatic release_done();
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic run0(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] eo, input logic eb);
    int edges, bc;
    start_op(av, bv);
    wait_done(edges, bc);
    check({tag, " latency"}, edges, 9);
    check({tag, " out"}, out0, eo);
    check({tag, " borrow"}, borrow0, eb);
    release_done();
    check({tag, " done released"}, done0, 1'b0);
    check({tag, " out held in idle"}, out0, eo);
  endtask

  initial begin
    int edges, bc;
    int t, last_rise, rises;
    logic prev_done;

    // Reset state
    #2;
    check("reset out", out0, 8'h00);
    check("reset borrow", borrow0, 1'b0);
    check("reset busy", busy0, 1'b0);
    check("reset done", done0, 1'b0);
    #10;
    rst_n = 1'b1;
    tick();

    // Test 1: 100 - 58, latency and busy duration
    start_op(8'd100, 8'd58);
    check("t1 busy after start", busy0, 1'b1);
    wait_done(edges, bc);
    check("t1 latency", edges, 9);
    check("t1 busy cycles", bc, 9);
    check("t1 out", out0, 8'd42);
    check("t1 borrow", borrow0, 1'b0);
    tick();
    check("t1 done is level", done0, 1'b1);
    release_done();
    check("t1 done released", done0, 1'b0);

    // Test 2: borrow and boundary cases
    run0("t2 5-9", 8'd5, 8'd9, 8'hFC, 1'b1);
    run0("t2 a5-a5", 8'hA5, 8'hA5, 8'h00, 1'b0);
    run0("t2 0-1", 8'd0, 8'd1, 8'hFF, 1'b1);

    // Test 3: descramble on both ports (default-mask instance)
    start_op(8'hE8 ^ 8'd200, 8'h96 ^ 8'd73);
    wait_done(edges, bc);
    check("t3 done1", done1, 1'b1);
    check("t3 out masked", out1, 8'd127);
    check("t3 borrow masked", borrow1, 1'b0);
    check("t3 out unmasked", out0, 8'h41);
    check("t3 borrow unmasked", borrow0, 1'b1);
    release_done();

    // Test 4: asynchronous reset on the 4th SUB cycle
    start_op(8'd100, 8'd58);
    for (int i = 0; i < 4; i++) tick();
    check("t4 partial out before reset", out0, 8'h40);
    rst_n = 1'b0;
    #1;
    check("t4 rst out", out0, 8'h00);
    check("t4 rst borrow", borrow0, 1'b0);
    check("t4 rst busy", busy0, 1'b0);
    check("t4 rst done", done0, 1'b0);
    #3;
    rst_n = 1'b1;
    tick();
    check("t4 idle after reset", {busy0, done0}, 2'b00);
    run0("t4 fresh", 8'd5, 8'd9, 8'hFC, 1'b1);

    // Test 5: operand churn and en pulse during LOAD/SUB are ignored
    start_op(8'd20, 8'd3);
    edges = 0;
    while (!done0 && edges < 20) begin
      a  = 8'($urandom);
      b  = 8'($urandom);
      en = (edges == 4);
      tick();
      edges++;
    end
    en = 1'b0;
    check("t5 latency", edges, 9);
    check("t5 out", out0, 8'd17);
    check("t5 borrow", borrow0, 1'b0);
    tick();
    tick();
    check("t5 no restart", {done0, busy0}, 2'b10);
    release_done();

    // Test 6: en held high -> back-to-back runs with 11-edge spacing
    a = 8'd20;
    b = 8'd3;
    en = 1'b1;
    prev_done = done0;
    last_rise = -1;
    rises = 0;
    for (t = 0; t < 35; t++) begin
      tick();
      if (done0 && !prev_done) begin
        check("t6 out", out0, 8'd17);
        if (last_rise >= 0) check("t6 spacing", t - last_rise, 11);
        last_rise = t;
        rises++;
      end
      prev_done = done0;
    end
    check("t6 run count", rises, 3);
    en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
